// File: rtl/sigan_pkg.sv
// Shared types for the sigan scan scheduler.
// Holds the FSM states, the result-table flag layout and the entry format.
package sigan_pkg;

  localparam int SIG_W  = 16;
  localparam int FLAG_W = 3;

  localparam int FLAG_VALID    = 0;
  localparam int FLAG_UNSTABLE = 1;
  localparam int FLAG_TIMEOUT  = 2;

  localparam int WIN_W = 4;
  localparam int TMO_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OPEN,
    IN_GATE,
    CAPTURE,
    ADVANCE
  } state_e;

  typedef struct packed {
    logic [SIG_W-1:0]  sig;
    logic [FLAG_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/sigan_result_table.sv
// Per-channel signature/flag register file.
// One synchronous write port, one combinational read port.
module sigan_result_table
  import sigan_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int CH_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [CH_W-1:0] wr_addr_i,
  input  entry_t          wr_data_i,
  input  logic [CH_W-1:0] rd_addr_i,
  output entry_t          rd_data_o
);

  entry_t mem_q [NCH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses past the last channel read as an empty entry.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_addr_i) < NCH) begin
      rd_data_o = mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/sigan_scan_ctrl.sv
// Sweeps one sigan analyzer over NCH probe channels, repeating
// MEAS gate windows per channel and logging the result per channel.
module sigan_scan_ctrl
  import sigan_pkg::*;
#(
  parameter  int NCH     = 8,
  parameter  int MEAS    = 2,
  parameter  int TIMEOUT = 1048575,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             run,
  input  logic             start,
  input  logic             stop,
  input  logic [SIG_W-1:0] sig_in,
  output logic [CH_W-1:0]  ch_sel,
  output logic             gate,
  output logic             busy,
  output logic             sweep_done,
  output logic [15:0]      sweep_count,
  input  logic [CH_W-1:0]  rd_addr,
  output logic [SIG_W-1:0] rd_sig,
  output logic [2:0]       rd_flags
);

  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(MEAS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  state_e           state_q;
  logic [CH_W-1:0]  ch_q;
  logic             gate_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      sweeps_q;
  logic [WIN_W-1:0] win_q;
  logic [TMO_W-1:0] tmo_q;
  logic [SIG_W-1:0] ref_q;
  logic             unst_q;

  logic [SIG_W-1:0] ref_d;
  logic             unst_d;
  logic             last_win;
  logic             tmo_evt;
  logic             wr_en;
  entry_t           wr_data;
  entry_t           rd_data;

  // Window 0 defines the reference; later windows only compare.
  always_comb begin
    ref_d    = (win_q == '0) ? sig_in : ref_q;
    unst_d   = unst_q | ((win_q != '0) && (sig_in != ref_q));
    last_win = (win_q == LAST_WIN);
    tmo_evt  = (tmo_q == TMO_LAST) &&
               (((state_q == WAIT_OPEN) && run) ||
                (state_q == IN_GATE));
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if ((state_q == CAPTURE) && last_win) begin
      wr_en                         = 1'b1;
      wr_data.sig                   = ref_d;
      wr_data.flags[FLAG_VALID]     = 1'b1;
      wr_data.flags[FLAG_UNSTABLE]  = unst_d;
    end else if (tmo_evt) begin
      wr_en                         = 1'b1;
      wr_data.flags[FLAG_VALID]     = 1'b1;
      wr_data.flags[FLAG_TIMEOUT]   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sweeps_q <= '0;
      win_q    <= '0;
      tmo_q    <= '0;
      ref_q    <= '0;
      unst_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= WAIT_OPEN;
            busy_q  <= 1'b1;
            ch_q    <= '0;
            win_q   <= '0;
            tmo_q   <= '0;
            unst_q  <= 1'b0;
          end
        end
        WAIT_OPEN: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (!run) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_evt) begin
            state_q <= ADVANCE;
          end else if (start) begin
            state_q <= IN_GATE;
            gate_q  <= 1'b1;
          end
        end
        IN_GATE: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (tmo_evt || stop) begin
            state_q <= tmo_evt ? ADVANCE : CAPTURE;
            gate_q  <= 1'b0;
          end
        end
        CAPTURE: begin
          ref_q  <= ref_d;
          unst_q <= unst_d;
          tmo_q  <= '0;
          if (last_win) begin
            state_q <= ADVANCE;
          end else begin
            win_q   <= win_q + WIN_W'(1);
            state_q <= WAIT_OPEN;
          end
        end
        ADVANCE: begin
          tmo_q  <= '0;
          win_q  <= '0;
          unst_q <= 1'b0;
          if (ch_q == CH_LAST) begin
            ch_q     <= '0;
            done_q   <= 1'b1;
            sweeps_q <= sweeps_q + 16'd1;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
          state_q <= run ? WAIT_OPEN : IDLE;
          busy_q  <= run;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  sigan_result_table #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_table (
    .clk_i     (clock),
    .rst_ni    (reset_l),
    .we_i      (wr_en),
    .wr_addr_i (ch_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign ch_sel      = ch_q;
  assign gate        = gate_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign sweep_count = sweeps_q;
  assign rd_sig      = rd_data.sig;
  assign rd_flags    = rd_data.flags;

endmodule

// File: tb/tb_sigan_scan_ctrl.sv
// Randomized directed bench for sigan_scan_ctrl.
// Expected table contents come from a per-channel window model.
module tb_sigan_scan_ctrl;

  localparam int NCH     = 3;
  localparam int MEAS    = 2;
  localparam int TIMEOUT = 100;
  localparam int CH_W    = 2;

  logic            clock   = 1'b0;
  logic            reset_l = 1'b0;
  logic            run     = 1'b0;
  logic            start   = 1'b0;
  logic            stop    = 1'b0;
  logic [15:0]     sig_in  = '0;
  logic [CH_W-1:0] rd_addr = '0;
  logic [CH_W-1:0] ch_sel;
  logic            gate;
  logic            busy;
  logic            sweep_done;
  logic [15:0]     sweep_count;
  logic [15:0]     rd_sig;
  logic [2:0]      rd_flags;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_sig [NCH];
  logic [2:0]  m_flg [NCH];
  int          m_sweeps;
  int          m_ch;

  sigan_scan_ctrl #(
    .NCH     (NCH),
    .MEAS    (MEAS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_l     (reset_l),
    .run         (run),
    .start       (start),
    .stop        (stop),
    .sig_in      (sig_in),
    .ch_sel      (ch_sel),
    .gate        (gate),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count),
    .rd_addr     (rd_addr),
    .rd_sig      (rd_sig),
    .rd_flags    (rd_flags)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input int c);
    rd_addr = CH_W'(c);
    #1;
    chk({tag, "_sig"}, 32'(rd_sig), 32'(m_sig[c]));
    chk({tag, "_flags"}, 32'(rd_flags), 32'(m_flg[c]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sig[i] = '0;
      m_flg[i] = '0;
    end
    m_sweeps = 0;
    m_ch     = 0;
  endtask

  // Entered with the DUT in WAIT_OPEN on channel m_ch.
  task automatic do_channel(input bit tmo);
    int          c;
    logic [15:0] w [MEAS];
    bit          unst;
    logic        saw_gate;
    c = m_ch;
    chk("ch_start", 32'(ch_sel), 32'(c));
    if (tmo) begin
      saw_gate = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        tick();
        saw_gate = saw_gate | gate;
      end
      chk("tmo_gate", 32'(saw_gate), 32'd0);
      chk_entry("tmo_pre", c);
      tick();
      m_sig[c] = 16'h0000;
      m_flg[c] = 3'b101;
      chk_entry("tmo_entry", c);
    end else begin
      w[0] = 16'($urandom);
      unst = 1'b0;
      for (int j = 1; j < MEAS; j++) begin
        if ($urandom_range(0, 1) == 1)
          w[j] = w[0];
        else
          w[j] = w[0] ^ 16'($urandom_range(1, 65535));
        unst = unst | (w[j] != w[0]);
      end
      for (int j = 0; j < MEAS; j++) begin
        repeat ($urandom_range(0, 4)) tick();
        start = 1'b1;
        stop  = 1'($urandom_range(0, 1));
        tick();
        chk("gate_open", 32'(gate), 32'd1);
        start = 1'b0;
        stop  = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        chk("gate_hold", 32'(gate), 32'd1);
        stop   = 1'b1;
        start  = 1'($urandom_range(0, 1));
        sig_in = w[j];
        tick();
        chk("gate_close", 32'(gate), 32'd0);
        chk("busy_cap", 32'(busy), 32'd1);
        start = 1'b0;
        stop  = 1'b0;
        if (j == MEAS - 1) chk_entry("pre_write", c);
        tick();
      end
      m_sig[c] = w[0];
      m_flg[c] = unst ? 3'b011 : 3'b001;
      chk_entry("entry", c);
    end
    chk("ch_adv_hold", 32'(ch_sel), 32'(c));
    tick();
    m_ch = (c + 1) % NCH;
    if (c == NCH - 1) m_sweeps = (m_sweeps + 1) & 32'hFFFF;
    chk("ch_next", 32'(ch_sel), 32'(m_ch));
    chk("sweep_done", 32'(sweep_done), 32'(c == NCH - 1));
    chk("sweep_count", 32'(sweep_count), 32'(m_sweeps));
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_ch", 32'(ch_sel), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_count", 32'(sweep_count), 32'd0);
    for (int i = 0; i < NCH; i++) chk_entry("rst_entry", i);
    reset_l = 1'b1;
    tick();
    chk("idle_hold", 32'(busy), 32'd0);

    run = 1'b1;
    tick();
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_ch", 32'(ch_sel), 32'd0);

    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < NCH; c++) begin
        do_channel((s == 1 && c == 1) ||
                   ($urandom_range(0, 7) == 0));
      end
    end

    // Async reset in the middle of a gate window on channel 1.
    do_channel(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_gate", 32'(gate), 32'd1);
    reset_l = 1'b0;
    #1;
    model_reset();
    chk("arst_gate", 32'(gate), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ch", 32'(ch_sel), 32'd0);
    chk("arst_count", 32'(sweep_count), 32'd0);
    for (int i = 0; i < NCH; i++) chk_entry("arst_entry", i);
    run     = 1'b0;
    reset_l = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Dropping run while waiting on channel 1.
    run = 1'b1;
    tick();
    do_channel(1'b0);
    run = 1'b0;
    tick();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_gate", 32'(gate), 32'd0);
    chk("drop_done", 32'(sweep_done), 32'd0);
    chk_entry("drop_e1", 1);
    tick();
    chk_entry("drop_e0", 0);
    run = 1'b1;
    tick();
    m_ch = 0;
    chk("restart_ch", 32'(ch_sel), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    do_channel(1'b0);
    run = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
